csr_serial_loader: RTL

- Serial front end that sits directly upstream of the PLL CSR register bank.
- Deserialises framed, parity-protected write commands from a 2-wire serial port (sdi, cs_n) into single-cycle addr/data write strobes for the bank.
- Rejects malformed frames and keeps status counters, so a reduced pin budget can still reconfigure all four PLL channels.

---
 rtl/csr_serial_loader.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/csr_serial_loader.sv
// Serial write front end for the PLL CSR bank: deserialises framed, parity-protected
// addr/data commands from cs_n/sdi into single-cycle write strobes and keeps error status.
module csr_serial_loader #(
    parameter int PARITY_EN = 1,
    parameter int ADDR_MAX  = 12,
    parameter int CNT_W     = 8
) (
    input  logic             clk_csr,
    input  logic             rst_n,
    input  logic             cs_n,
    input  logic             sdi,
    input  logic             clr_status,
    output logic             wr_en,
    output logic [3:0]       wr_addr,
    output logic [3:0]       wr_data,
    output logic             busy,
    output logic             parity_err,
    output logic             addr_err,
    output logic             abort_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [3:0]       err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] FRAME_LEN = (PARITY_EN != 0) ? 4'd9 : 4'd8;
    localparam logic [3:0] LAST_IDX  = FRAME_LEN - 4'd1;
    localparam logic [3:0] ADDR_LIM  = 4'(ADDR_MAX);

    function automatic logic even_parity_ok(input logic [8:0] frame);
        return ((^frame) == 1'b0);
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       sr_q, sr_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic             wr_en_q, wr_en_d;
    logic [3:0]       wr_addr_q, wr_addr_d;
    logic [3:0]       wr_data_q, wr_data_d;
    logic             busy_q, busy_d;
    logic             parity_err_q, parity_err_d;
    logic             addr_err_q, addr_err_d;
    logic             abort_err_q, abort_err_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]       err_cnt_q, err_cnt_d;

    logic [8:0] frame_s;
    logic [3:0] addr_s;
    logic [3:0] data_s;
    logic       par_fail_s;
    logic       addr_fail_s;
    logic       last_bit_s;
    logic       abort_s;
    logic       accept_s;
    logic       reject_s;

    // The frame is evaluated with the final bit taken straight from sdi, not from the shift register.
    always_comb begin
        frame_s = {sr_q, sdi};
        if (PARITY_EN != 0) begin
            addr_s     = frame_s[8:5];
            data_s     = frame_s[4:1];
            par_fail_s = ~even_parity_ok(frame_s);
        end else begin
            addr_s     = frame_s[7:4];
            data_s     = frame_s[3:0];
            par_fail_s = 1'b0;
        end
        addr_fail_s = (addr_s > ADDR_LIM);
    end

    // Frame sequencing: IDLE -> SHIFT while bits arrive -> HOLD until cs_n releases.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        last_bit_s = 1'b0;
        abort_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!cs_n) begin
                    sr_d      = {7'd0, sdi};
                    bit_cnt_d = 4'd1;
                    state_d   = ST_SHIFT;
                end else begin
                    bit_cnt_d = 4'd0;
                end
            end
            ST_SHIFT: begin
                if (!cs_n) begin
                    sr_d = {sr_q[6:0], sdi};
                    if (bit_cnt_q == LAST_IDX) begin
                        last_bit_s = 1'b1;
                        bit_cnt_d  = FRAME_LEN;
                        state_d    = ST_HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    abort_s   = 1'b1;
                    bit_cnt_d = 4'd0;
                    state_d   = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cs_n) begin
                    bit_cnt_d = 4'd0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                bit_cnt_d = 4'd0;
                state_d   = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_SHIFT);
    end

    // Write strobe and sticky status; a concurrent clear beats any event but never the strobe.
    always_comb begin
        accept_s  = last_bit_s & ~par_fail_s & ~addr_fail_s;
        reject_s  = abort_s | (last_bit_s & (par_fail_s | addr_fail_s));
        wr_en_d   = accept_s;
        wr_addr_d = accept_s ? addr_s : wr_addr_q;
        wr_data_d = accept_s ? data_s : wr_data_q;
        if (clr_status) begin
            parity_err_d = 1'b0;
            addr_err_d   = 1'b0;
            abort_err_d  = 1'b0;
            frame_cnt_d  = {CNT_W{1'b0}};
            err_cnt_d    = 4'd0;
        end else begin
            parity_err_d = parity_err_q | (last_bit_s & par_fail_s);
            addr_err_d   = addr_err_q | (last_bit_s & ~par_fail_s & addr_fail_s);
            abort_err_d  = abort_err_q | abort_s;
            if (accept_s && (frame_cnt_q != {CNT_W{1'b1}})) begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end else begin
                frame_cnt_d = frame_cnt_q;
            end
            if (reject_s && (err_cnt_q != 4'hF)) begin
                err_cnt_d = err_cnt_q + 4'd1;
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_csr or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sr_q         <= 8'd0;
            bit_cnt_q    <= 4'd0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 4'd0;
            wr_data_q    <= 4'd0;
            busy_q       <= 1'b0;
            parity_err_q <= 1'b0;
            addr_err_q   <= 1'b0;
            abort_err_q  <= 1'b0;
            frame_cnt_q  <= {CNT_W{1'b0}};
            err_cnt_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            parity_err_q <= parity_err_d;
            addr_err_q   <= addr_err_d;
            abort_err_q  <= abort_err_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign parity_err = parity_err_q;
    assign addr_err   = addr_err_q;
    assign abort_err  = abort_err_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule
